// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between an async FIFO and its UART transmitter.
// master = the consumer that pops; slave = the FIFO that supplies data.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              EMPTY;
  logic [DATA_W-1:0] READ_DATA;
  logic              READ_ENABLE;

  modport master (
    output READ_ENABLE,
    input  EMPTY,
    input  READ_DATA
  );

  modport slave (
    input  READ_ENABLE,
    output EMPTY,
    output READ_DATA
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an async FIFO (read-clock domain) and sends them as 8N1 UART frames.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 16
) (
  input  logic             RCLK,
  input  logic             RST,
  input  logic             TX_ENABLE,
  fifo_uart_tx_if.master   fifo,
  output logic             TX_SERIAL,
  output logic             BUSY,
  output logic             BYTE_DONE,
  output logic [CNT_W-1:0] BYTE_COUNT
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t            state, state_n;
  logic [DIV_W-1:0]  div, div_n;
  logic [BIT_W-1:0]  bit_idx, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              bit_end;
  logic              tx_n, busy_n, done_n, re_n;
`ifdef UART_TX_PARITY_EN
  logic              parity, parity_n;
`endif

  assign bit_end = (div == DIV_LAST);

  // Outputs are derived from the next state so that every output is a flop.
  always_comb begin
    state_n = state;
    div_n   = div;
    bit_n   = bit_idx;
    shift_n = shift;
`ifdef UART_TX_PARITY_EN
    parity_n = parity;
`endif
    tx_n    = 1'b1;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    re_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        div_n = '0;
        if (TX_ENABLE && !fifo.EMPTY) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        shift_n = fifo.READ_DATA;
`ifdef UART_TX_PARITY_EN
        parity_n = ^fifo.READ_DATA;
`endif
        div_n   = '0;
        state_n = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          div_n   = '0;
          bit_n   = '0;
          state_n = ST_DATA;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          div_n   = '0;
          shift_n = shift >> 1;
          if (bit_idx == BIT_LAST) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          div_n   = '0;
          state_n = ST_STOP;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          div_n   = '0;
          state_n = ST_IDLE;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      default: begin
        div_n   = '0;
        state_n = ST_IDLE;
      end
    endcase

    re_n   = (state_n == ST_FETCH);
    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_STOP) && (div_n == DIV_LAST);

    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_n = parity_n;
`endif
      default:   tx_n = 1'b1;
    endcase
  end

  // Reset drops the frame on the spot: line back to idle-high, byte not counted.
  always_ff @(posedge RCLK or negedge RST) begin
    if (!RST) begin
      state            <= ST_IDLE;
      div              <= '0;
      bit_idx          <= '0;
      shift            <= '0;
`ifdef UART_TX_PARITY_EN
      parity           <= 1'b0;
`endif
      TX_SERIAL        <= 1'b1;
      BUSY             <= 1'b0;
      BYTE_DONE        <= 1'b0;
      fifo.READ_ENABLE <= 1'b0;
      BYTE_COUNT       <= '0;
    end else begin
      state            <= state_n;
      div              <= div_n;
      bit_idx          <= bit_n;
      shift            <= shift_n;
`ifdef UART_TX_PARITY_EN
      parity           <= parity_n;
`endif
      TX_SERIAL        <= tx_n;
      BUSY             <= busy_n;
      BYTE_DONE        <= done_n;
      fifo.READ_ENABLE <= re_n;
      if (done_n && (BYTE_COUNT != '1)) BYTE_COUNT <= BYTE_COUNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model on the read side.
// Frame expectations follow UART_TX_PARITY_EN when it is defined.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME  = NB * CPB;
  localparam int PERIOD = FRAME + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_enable = 1'b0;
  logic        tx_serial;
  logic        busy;
  logic        byte_done;
  logic [15:0] byte_count;

  fifo_uart_tx_if #(.DATA_W(8)) fif ();

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(8),
    .CNT_W(16)
  ) dut (
    .RCLK(clk),
    .RST(rst_n),
    .TX_ENABLE(tx_enable),
    .fifo(fif),
    .TX_SERIAL(tx_serial),
    .BUSY(busy),
    .BYTE_DONE(byte_done),
    .BYTE_COUNT(byte_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  int cyc = 0;
  int re_pulses = 0;
  int underflows = 0;
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] mem [0:63];

  always_comb fif.EMPTY = (wr_ptr == rd_ptr);

  // FIFO model: data for a pop appears the cycle after READ_ENABLE.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fif.READ_ENABLE === 1'b1) begin
      re_pulses <= re_pulses + 1;
      if (wr_ptr != rd_ptr) begin
        fif.READ_DATA <= mem[rd_ptr % 64];
        rd_ptr <= rd_ptr + 1;
      end else begin
        underflows <= underflows + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
    logic [NB-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic wait_start(output int t, output bit found);
    found = 1'b0;
    t = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (tx_serial === 1'b0) begin
        found = 1'b1;
        t = cyc;
      end
    end
  endtask

  // Starts on the first START cycle, ends on the idle cycle after STOP.
  task automatic capture_frame(input int drop_at, output logic [NB-1:0] bits,
                               output bit stable, output int done_idx, output int done_cnt);
    stable = 1'b1;
    done_cnt = 0;
    done_idx = -1;
    bits = '0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == drop_at) tx_enable = 1'b0;
      if (i % CPB == 0) bits[i / CPB] = tx_serial;
      else if (tx_serial !== bits[i / CPB]) stable = 1'b0;
      if (byte_done === 1'b1) begin
        done_cnt++;
        done_idx = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_enable = 1'b1;
    push(8'h11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (fif.READ_ENABLE !== 1'b0) begin errors++; $display("[TB] FAIL reset_re: got %0b expected 0", fif.READ_ENABLE); end
      checks++;
      if (tx_serial !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %0b expected 1", tx_serial); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
      checks++;
      if (byte_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", byte_count); end
    end
  endtask

  task automatic test_single_byte();
    int c0, t, re0, didx, dcnt;
    bit found, stable;
    logic [NB-1:0] bits;
    re0 = re_pulses;
    c0 = cyc;
    rst_n = 1'b1;
    wait_start(t, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL single_start: got none expected start bit"); end
    checks++;
    if (t - c0 !== 3) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 3", t - c0); end
    capture_frame(-1, bits, stable, didx, dcnt);
    checks++;
    if (bits !== frame_of(8'h11)) begin errors++; $display("[TB] FAIL single_bits: got %0h expected %0h", bits, frame_of(8'h11)); end
    checks++;
    if (!stable) begin errors++; $display("[TB] FAIL single_stable: got glitch expected steady bits"); end
    checks++;
    if (dcnt !== 1) begin errors++; $display("[TB] FAIL single_done_cnt: got %0d expected 1", dcnt); end
    checks++;
    if (didx !== FRAME - 1) begin errors++; $display("[TB] FAIL single_done_pos: got %0d expected %0d", didx, FRAME - 1); end
    exp_count++;
    checks++;
    if (byte_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", byte_count, exp_count); end
    checks++;
    if (re_pulses - re0 !== 1) begin errors++; $display("[TB] FAIL single_pops: got %0d expected 1", re_pulses - re0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int t, tprev, re0, didx, dcnt;
    bit found, stable;
    logic [NB-1:0] bits;
    re0 = re_pulses;
    tprev = 0;
    for (int k = 0; k < 4; k++) push(data[k]);
    for (int k = 0; k < 4; k++) begin
      wait_start(t, found);
      checks++;
      if (!found) begin errors++; $display("[TB] FAIL b2b_start%0d: got none expected start bit", k); end
      if (k > 0) begin
        checks++;
        if (t - tprev !== PERIOD) begin errors++; $display("[TB] FAIL b2b_spacing%0d: got %0d expected %0d", k, t - tprev, PERIOD); end
      end
      tprev = t;
      capture_frame(-1, bits, stable, didx, dcnt);
      checks++;
      if (bits !== frame_of(data[k]) || !stable) begin
        errors++; $display("[TB] FAIL b2b_bits%0d: got %0h expected %0h", k, bits, frame_of(data[k]));
      end
      exp_count++;
    end
    checks++;
    if (byte_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", byte_count, exp_count); end
    repeat (10) @(negedge clk);
    checks++;
    if (re_pulses - re0 !== 4) begin errors++; $display("[TB] FAIL b2b_pops: got %0d expected 4", re_pulses - re0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy: got %0b expected 0", busy); end
    checks++;
    if (underflows !== 0) begin errors++; $display("[TB] FAIL b2b_underflow: got %0d expected 0", underflows); end
  endtask

  task automatic test_enable_drop();
    int t, re0, didx, dcnt;
    bit found, stable;
    logic [NB-1:0] bits;
    re0 = re_pulses;
    push(8'h55);
    push(8'h66);
    wait_start(t, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL drop_start: got none expected start bit"); end
    capture_frame(2 * CPB + 1, bits, stable, didx, dcnt);
    checks++;
    if (bits !== frame_of(8'h55) || !stable) begin errors++; $display("[TB] FAIL drop_bits: got %0h expected %0h", bits, frame_of(8'h55)); end
    checks++;
    if (dcnt !== 1) begin errors++; $display("[TB] FAIL drop_done: got %0d expected 1", dcnt); end
    exp_count++;
    repeat (20) @(negedge clk);
    checks++;
    if (re_pulses - re0 !== 1) begin errors++; $display("[TB] FAIL drop_pops: got %0d expected 1", re_pulses - re0); end
    checks++;
    if (busy !== 1'b0 || tx_serial !== 1'b1) begin errors++; $display("[TB] FAIL drop_idle: got busy=%0b tx=%0b expected busy=0 tx=1", busy, tx_serial); end
    tx_enable = 1'b1;
    wait_start(t, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL drop_resume: got none expected start bit"); end
    capture_frame(-1, bits, stable, didx, dcnt);
    checks++;
    if (bits !== frame_of(8'h66) || !stable) begin errors++; $display("[TB] FAIL drop_bits2: got %0h expected %0h", bits, frame_of(8'h66)); end
    exp_count++;
    checks++;
    if (byte_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL drop_count: got %0d expected %0d", byte_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    int t, didx, dcnt;
    bit found, stable;
    logic [NB-1:0] bits;
    push(8'h77);
    push(8'h88);
    wait_start(t, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL rmid_start: got none expected start bit"); end
    repeat (4 * CPB + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_serial !== 1'b1) begin errors++; $display("[TB] FAIL rmid_tx: got %0b expected 1", tx_serial); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %0b expected 0", busy); end
    checks++;
    if (byte_count !== 16'd0) begin errors++; $display("[TB] FAIL rmid_count: got %0d expected 0", byte_count); end
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(t, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL rmid_restart: got none expected start bit"); end
    capture_frame(-1, bits, stable, didx, dcnt);
    checks++;
    if (bits !== frame_of(8'h88) || !stable) begin errors++; $display("[TB] FAIL rmid_bits: got %0h expected %0h", bits, frame_of(8'h88)); end
    exp_count++;
    checks++;
    if (byte_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL rmid_count2: got %0d expected %0d", byte_count, exp_count); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int t0, t1, didx, dcnt;
    bit found, stable;
    logic [NB-1:0] bits;
    push(8'h07);
    push(8'hA5);
    wait_start(t0, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL par_start0: got none expected start bit"); end
    capture_frame(-1, bits, stable, didx, dcnt);
    checks++;
    if (bits[9] !== 1'b1) begin errors++; $display("[TB] FAIL par_bit0: got %0b expected 1", bits[9]); end
    checks++;
    if (bits !== frame_of(8'h07) || !stable) begin errors++; $display("[TB] FAIL par_frame0: got %0h expected %0h", bits, frame_of(8'h07)); end
    checks++;
    if (didx !== 43) begin errors++; $display("[TB] FAIL par_done_pos: got %0d expected 43", didx); end
    wait_start(t1, found);
    checks++;
    if (t1 - t0 !== 47) begin errors++; $display("[TB] FAIL par_spacing: got %0d expected 47", t1 - t0); end
    capture_frame(-1, bits, stable, didx, dcnt);
    checks++;
    if (bits[9] !== 1'b0) begin errors++; $display("[TB] FAIL par_bit1: got %0b expected 0", bits[9]); end
    checks++;
    if (bits !== frame_of(8'hA5) || !stable) begin errors++; $display("[TB] FAIL par_frame1: got %0h expected %0h", bits, frame_of(8'hA5)); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
